// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator: state and result
// encodings plus the sizing helpers used by the top, the interface and the bench.
package seq_cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One-hot {gt, eq, lt}; exactly one bit is set for any finished result
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic int calc_cnt_w(input int nslice);
    return $clog2(nslice + 1);
  endfunction

  function automatic int calc_idx_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result handshake bundle for seq_magnitude_comparator.
// master = producer/consumer side, slave = comparator side.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [CNT_W-1:0] slices_used;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gt, eq, lt, slices_used
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gt, eq, lt, slices_used
  );
endinterface

// File: rtl/seq_magnitude_comparator_cmp_slice.sv
// Combinational SLICE-bit magnitude compare; inv flips both operand MSBs so the
// top slice of a two's-complement pair orders correctly as unsigned.
module cmp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             inv,
  output logic             gt,
  output logic             lt
);
  localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

  logic [SLICE-1:0] a_m_s;
  logic [SLICE-1:0] b_m_s;

  // Optional sign-bit flip followed by an unsigned compare
  always_comb begin
    a_m_s = a;
    b_m_s = b;
    if (inv) begin
      a_m_s = a ^ MSB_MASK;
      b_m_s = b ^ MSB_MASK;
    end else begin
      a_m_s = a;
      b_m_s = b;
    end
    gt = (a_m_s > b_m_s);
    lt = (a_m_s < b_m_s);
  end
endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit comparator, one SLICE per clock, MSB slice first.
// Optional early exit on the first differing slice: SEQ_CMP_EARLY_TERM_EN.
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SLICE  = 4,
  parameter int SIGNED = 0
) (
  input logic                      clk,
  input logic                      rst_n,
  seq_magnitude_comparator_if.slave bus
);
  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int CNT_W  = calc_cnt_w(NSLICE);
  localparam int IDX_W  = calc_idx_w(NSLICE);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);

  logic [1:0]                         state_r;
  logic [NSLICE-1:0][SLICE-1:0]       a_r;
  logic [NSLICE-1:0][SLICE-1:0]       b_r;
  logic [IDX_W-1:0]                   idx_r;
  logic                               decided_r;
  logic                               gt_r;
  logic                               lt_r;
  logic [CNT_W-1:0]                   count_r;
  logic                               out_valid_r;
  logic [2:0]                         res_r;
  logic [CNT_W-1:0]                   su_r;

  logic             inv_s;
  logic             slice_gt_s;
  logic             slice_lt_s;
  logic             hit_s;
  logic             dec_next_s;
  logic             gt_next_s;
  logic             lt_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             exit_s;
  logic [2:0]       res_next_s;

  assign inv_s = (SIGNED != 0) && (idx_r == IDX_TOP);

  cmp_slice #(.SLICE(SLICE)) u_slice (
    .a   (a_r[idx_r]),
    .b   (b_r[idx_r]),
    .inv (inv_s),
    .gt  (slice_gt_s),
    .lt  (slice_lt_s)
  );

  // Next decision state: a result, once decided, is never overwritten
  always_comb begin
    hit_s      = slice_gt_s | slice_lt_s;
    dec_next_s = decided_r | hit_s;
    cnt_next_s = count_r + CNT_W'(1);
    gt_next_s  = gt_r;
    lt_next_s  = lt_r;
    if (!decided_r) begin
      gt_next_s = slice_gt_s;
      lt_next_s = slice_lt_s;
    end else begin
      gt_next_s = gt_r;
      lt_next_s = lt_r;
    end
`ifdef SEQ_CMP_EARLY_TERM_EN
    exit_s = (idx_r == '0) | (hit_s & ~decided_r);
`else
    exit_s = (idx_r == '0);
`endif
    res_next_s = CMP_EQ;
    if (!dec_next_s) begin
      res_next_s = CMP_EQ;
    end else if (gt_next_s) begin
      res_next_s = CMP_GT;
    end else begin
      res_next_s = CMP_LT;
    end
  end

  // FSM, operand capture, slice walk and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      idx_r       <= '0;
      decided_r   <= 1'b0;
      gt_r        <= 1'b0;
      lt_r        <= 1'b0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      res_r       <= 3'b000;
      su_r        <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_r       <= bus.a;
            b_r       <= bus.b;
            idx_r     <= IDX_TOP;
            decided_r <= 1'b0;
            gt_r      <= 1'b0;
            lt_r      <= 1'b0;
            count_r   <= '0;
            state_r   <= ST_CMP;
          end
        end
        ST_CMP: begin
          decided_r <= dec_next_s;
          gt_r      <= gt_next_s;
          lt_r      <= lt_next_s;
          count_r   <= cnt_next_s;
          if (exit_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            res_r       <= res_next_s;
            su_r        <= cnt_next_s;
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_r == ST_IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.gt          = res_r[2];
  assign bus.eq          = res_r[1];
  assign bus.lt          = res_r[0];
  assign bus.slices_used = su_r;

endmodule
